clock_divider_multi: RTL
========================

Name: clock_divider_multi

Overview:
- Multi-channel, runtime-programmable clock/tick generator; successor to the single fixed 5,000,000-count FND divider.
- Drives FND digit-scan clocks, blink clocks and debounce sample ticks from one block on i_clk (100 MHz system clock).
- Each channel has its own divisor, enable and output mode.
- Divisor changes are glitch-free: a new divisor is applied only at a terminal count.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- CNT_W, 32, counter/divisor width in bits.
- DEFAULT_DIV, 5_000_000, divisor loaded into every channel at reset.
- CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel select width (derived; do not override).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  NUM_CH  per-channel count enable.
- i_mode  in  NUM_CH  per-channel output mode: 0 = toggle (50% clock), 1 = pulse.
- i_div_wr  in  1  divisor write strobe, one cycle.
- i_div_sel  in  CH_W  channel addressed by i_div_wr.
- i_div_val  in  CNT_W  new divisor value.
- i_sync  in  1  synchronous restart of all channels (phase alignment).
- o_clk  out  NUM_CH  per-channel divided clock/pulse output, registered.
- o_tick  out  NUM_CH  per-channel one-cycle terminal-count strobe, registered.

Behaviour:
- Reset is asynchronous. On reset, per channel:
  - counter = 0, div_active = DEFAULT_DIV, div_pending = 0, pend_valid = 0.
  - o_clk = 0, o_tick = 0.
- Effective divisor: D = max(div_active, 1). A written value of 0 is stored as-is but counts as 1.
- Counting, when i_enable[ch]=1:
  - if counter == D-1: counter <= 0 (terminal count, TC).
  - otherwise: counter <= counter+1.
- When i_enable[ch]=0:
  - counter and o_clk hold; o_tick = 0.
  - A pending divisor is not applied until a TC occurs.
- o_tick[ch] is 1 for exactly the cycle after each TC, in both modes. Period = D cycles.
- Toggle mode (i_mode=0): o_clk inverts at each TC. Period = 2*D cycles, 50% duty. For D=1, o_clk toggles every cycle.
- Pulse mode (i_mode=1): o_clk = o_tick.
- Mode change takes effect on the next cycle.
- Changing from toggle to pulse drives o_clk from o_tick on the next cycle; the toggle state is then discarded.
- Divisor write, when i_div_wr=1:
  - div_pending[i_div_sel] <= i_div_val; pend_valid <= 1.
  - An i_div_sel value >= NUM_CH is ignored.
  - A second write before it is applied overwrites the pending value (last write wins).
- Apply rule: at a TC with pend_valid=1 (as registered before this cycle), div_active <= div_pending and pend_valid <= 0.
  - A write in the same cycle as a TC is applied at the following TC.
- i_sync=1, all channels, same cycle, overriding the count:
  - counter <= 0, o_clk <= 0, o_tick <= 0.
  - Any pending divisor is applied immediately, if pend_valid was already set.
- i_sync together with i_div_wr: the written value becomes pending; it is not applied by this sync.
- Counter width: if CNT_W is too small, DEFAULT_DIV truncates to CNT_W bits. Keep DEFAULT_DIV < 2^CNT_W.
- No combinational path from any input to any output.

Optional Feature:
- Macro: CLKDIV_READBACK_EN.
- Defined: adds output port o_rd_div (CNT_W).
  - Registered copy of div_active[i_div_sel], valid one cycle after i_div_sel changes.
  - Reset value DEFAULT_DIV.
  - An out-of-range i_div_sel reads 0.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset (DEFAULT_DIV=4, NUM_CH=2), release, enables=11, modes=00 -> o_tick pulses every 4 cycles; o_clk period 8 cycles, 4 high / 4 low; both channels in phase.
- ch1 i_mode=1 -> o_clk[1] is high 1 cycle every 4 cycles and equals o_tick[1]; ch0 unaffected.
- Write div=2 to ch0 mid-count (counter=1) -> old period completes; after that TC, o_tick[0] every 2 cycles. Write div=0 -> every cycle.
- Write div=6 then div=3 to ch1 before its TC -> only 3 is applied. Write on the exact TC cycle -> applied one TC later.
- Drop i_enable[0] for 10 cycles -> counter and o_clk frozen, no o_tick. Re-enable -> counting resumes from the held value.
- Pending write on ch0, then i_sync -> all counters=0, o_clk=0, ch0 uses the new divisor immediately. Assert i_reset mid-count -> outputs 0 asynchronously and divisors return to 4.

Source files
------------

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock/tick divider with glitch-free divisor updates.
// Optional divisor readback port is enabled by defining CLKDIV_READBACK_EN.
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 5_000_000,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_enable,
  input  logic [NUM_CH-1:0] i_mode,
  input  logic              i_div_wr,
  input  logic [CH_W-1:0]   i_div_sel,
  input  logic [CNT_W-1:0]  i_div_val,
  input  logic              i_sync,
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick
`ifdef CLKDIV_READBACK_EN
  ,
  output logic [CNT_W-1:0]  o_rd_div
`endif
);

  localparam logic [CNT_W-1:0] DEF_DIV   = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CH_W:0]    CH_LIMIT  = (CH_W+1)'(NUM_CH);

  logic sel_ok;
  assign sel_ok = ({1'b0, i_div_sel} < CH_LIMIT);

`ifdef CLKDIV_READBACK_EN
  logic [NUM_CH-1:0][CNT_W-1:0] div_active_all;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] div_active_q, div_active_d;
      logic [CNT_W-1:0] div_pending_q, div_pending_d;
      logic             pend_valid_q, pend_valid_d;
      logic             clk_q, clk_d;
      logic             tick_q, tick_d;
      logic [CNT_W-1:0] term_val;
      logic             tc;
      logic             wr_hit;

      // A stored divisor of 0 behaves as 1, so its terminal value is 0.
      assign term_val = (div_active_q == '0) ? '0 : (div_active_q - ONE);
      assign tc       = i_enable[gi] & (cnt_q == term_val);
      assign wr_hit   = i_div_wr & sel_ok & (i_div_sel == CH_W'(gi));

      always_comb begin
        cnt_d         = cnt_q;
        div_active_d  = div_active_q;
        div_pending_d = div_pending_q;
        pend_valid_d  = pend_valid_q;
        clk_d         = clk_q;
        tick_d        = 1'b0;

        if (i_sync) begin
          cnt_d  = '0;
          clk_d  = 1'b0;
          tick_d = 1'b0;
          if (pend_valid_q) begin
            div_active_d = div_pending_q;
            pend_valid_d = 1'b0;
          end
        end else if (i_enable[gi]) begin
          tick_d = tc;
          cnt_d  = tc ? '0 : (cnt_q + ONE);
          if (tc && pend_valid_q) begin
            div_active_d = div_pending_q;
            pend_valid_d = 1'b0;
          end
          clk_d = i_mode[gi] ? tc : (clk_q ^ tc);
        end else begin
          // Pulse mode mirrors the (zero) tick; toggle mode freezes its level.
          clk_d = i_mode[gi] ? 1'b0 : clk_q;
        end

        // Applied after the TC/sync transfer so a coincident write stays pending.
        if (wr_hit) begin
          div_pending_d = i_div_val;
          pend_valid_d  = 1'b1;
        end
      end

      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          cnt_q         <= '0;
          div_active_q  <= DEF_DIV;
          div_pending_q <= '0;
          pend_valid_q  <= 1'b0;
          clk_q         <= 1'b0;
          tick_q        <= 1'b0;
        end else begin
          cnt_q         <= cnt_d;
          div_active_q  <= div_active_d;
          div_pending_q <= div_pending_d;
          pend_valid_q  <= pend_valid_d;
          clk_q         <= clk_d;
          tick_q        <= tick_d;
        end
      end

      assign o_clk[gi]  = clk_q;
      assign o_tick[gi] = tick_q;
`ifdef CLKDIV_READBACK_EN
      assign div_active_all[gi] = div_active_q;
`endif
    end
  endgenerate

`ifdef CLKDIV_READBACK_EN
  logic [CNT_W-1:0] rd_div_q, rd_div_d;

  always_comb begin
    rd_div_d = '0;
    if (sel_ok) begin
      rd_div_d = div_active_all[i_div_sel];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_div_q <= DEF_DIV;
    end else begin
      rd_div_q <= rd_div_d;
    end
  end

  assign o_rd_div = rd_div_q;
`endif

endmodule
